// File: rtl/mic_load_stereo.sv
// Stereo CODEC ADC receiver: deserialises LJ or I2S framed ADCDAT into left/right
// sample pairs and queues them in a first-word-fall-through FIFO with ready/valid.
module mic_load_stereo #(
    parameter int N        = 16,
    parameter int DEPTH    = 4,
    parameter int I2S_MODE = 0
) (
    input  logic                     bclk,
    input  logic                     reset_n,
    input  logic                     adclrc,
    input  logic                     adcdat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_left,
    output logic [N-1:0]             out_right,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic                     sync_err,
    input  logic                     clear_flags
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, WAIT} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic            chan_right_reg, chan_right_next;
    logic [N-1:0]    shift_reg, shift_next;
    logic [N-1:0]    hold_left_reg, hold_left_next;
    logic            hold_valid_reg, hold_valid_next;
    logic            push_pend_reg, push_pend_next;
    logic [N-1:0]    push_right_reg, push_right_next;
    logic            adclrc_q_reg;
    logic            overrun_reg, sync_err_reg;
    logic [LW-1:0]   wr_cnt_reg, rd_cnt_reg;
    logic [2*N-1:0]  mem [DEPTH];

    logic            chan_edge, rise_edge, fall_edge, left_start, right_start;
    logic            start_left, start_right, sync_set;
    logic [N-1:0]    shifted;
    logic [LW-1:0]   level_w;
    logic            fifo_full, pop, push_ok, push_drop;

    assign chan_edge   = adclrc != adclrc_q_reg;
    assign rise_edge   = adclrc & ~adclrc_q_reg;
    assign fall_edge   = ~adclrc & adclrc_q_reg;
    assign left_start  = (I2S_MODE != 0) ? fall_edge : rise_edge;
    assign right_start = (I2S_MODE != 0) ? rise_edge : fall_edge;

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        chan_right_next = chan_right_reg;
        shift_next      = shift_reg;
        hold_left_next  = hold_left_reg;
        hold_valid_next = hold_valid_reg;
        push_pend_next  = 1'b0;
        push_right_next = push_right_reg;
        sync_set        = 1'b0;
        start_left      = 1'b0;
        start_right     = 1'b0;
        shifted         = {shift_reg[N-2:0], adcdat};

        case (state_reg)
            IDLE: begin
                start_left = left_start;
            end
            DELAY, SHIFT: begin
                if (chan_edge) begin
                    // Channel ended early: drop the partial word and follow the new channel.
                    sync_set    = 1'b1;
                    start_left  = left_start;
                    start_right = right_start && hold_valid_reg;
                    if (!start_left && !start_right) begin
                        state_next = IDLE;
                    end
                end else if (state_reg == DELAY) begin
                    shift_next   = shifted;
                    bit_cnt_next = CW'(1);
                    state_next   = SHIFT;
                end else begin
                    shift_next = shifted;
                    if (bit_cnt_reg == CW'(N - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = WAIT;
                        if (chan_right_reg) begin
                            push_pend_next  = 1'b1;
                            push_right_next = shifted;
                            hold_valid_next = 1'b0;
                        end else begin
                            hold_left_next  = shifted;
                            hold_valid_next = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CW'(1);
                    end
                end
            end
            WAIT: begin
                start_left  = left_start;
                start_right = right_start && hold_valid_reg;
            end
            default: state_next = IDLE;
        endcase

        if (start_left || start_right) begin
            chan_right_next = start_right;
            if (start_left) begin
                hold_valid_next = 1'b0;
            end
            if (I2S_MODE != 0) begin
                bit_cnt_next = '0;
                state_next   = DELAY;
            end else begin
                // LJ: the bit sampled with the channel edge is already the MSB.
                shift_next   = shifted;
                bit_cnt_next = CW'(1);
                state_next   = SHIFT;
            end
        end
    end

    assign level_w   = wr_cnt_reg - rd_cnt_reg;
    assign fifo_full = level_w == LW'(DEPTH);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push_pend_reg && (!fifo_full || pop);
    assign push_drop = push_pend_reg && !push_ok;

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            chan_right_reg <= 1'b0;
            shift_reg      <= '0;
            hold_left_reg  <= '0;
            hold_valid_reg <= 1'b0;
            push_pend_reg  <= 1'b0;
            push_right_reg <= '0;
            adclrc_q_reg   <= 1'b0;
            overrun_reg    <= 1'b0;
            sync_err_reg   <= 1'b0;
            wr_cnt_reg     <= '0;
            rd_cnt_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            chan_right_reg <= chan_right_next;
            shift_reg      <= shift_next;
            hold_left_reg  <= hold_left_next;
            hold_valid_reg <= hold_valid_next;
            push_pend_reg  <= push_pend_next;
            push_right_reg <= push_right_next;
            adclrc_q_reg   <= adclrc;
            // A set event outranks a simultaneous clear.
            overrun_reg    <= push_drop ? 1'b1 : (clear_flags ? 1'b0 : overrun_reg);
            sync_err_reg   <= sync_set  ? 1'b1 : (clear_flags ? 1'b0 : sync_err_reg);
            if (push_ok) begin
                wr_cnt_reg <= wr_cnt_reg + LW'(1);
            end
            if (pop) begin
                rd_cnt_reg <= rd_cnt_reg + LW'(1);
            end
        end
    end

    always_ff @(posedge bclk) begin
        if (push_ok) begin
            mem[wr_cnt_reg[AW-1:0]] <= {hold_left_reg, push_right_reg};
        end
    end

    assign out_valid = level_w != '0;
    assign level     = level_w;
    assign overrun   = overrun_reg;
    assign sync_err  = sync_err_reg;
    assign out_left  = out_valid ? mem[rd_cnt_reg[AW-1:0]][2*N-1:N] : '0;
    assign out_right = out_valid ? mem[rd_cnt_reg[AW-1:0]][N-1:0]   : '0;

endmodule

// File: tb/tb_mic_load_stereo.sv
// Bench for mic_load_stereo: one LJ and one I2S instance, frames scoreboarded
// through per-instance queues and compared whenever the consumer pops.
module tb_mic_load_stereo;
    logic        bclk = 1'b0;
    logic        reset_n;
    logic        lj_lrc, lj_dat, lj_ready, lj_clr;
    logic        i2s_lrc, i2s_dat, i2s_ready, i2s_clr;
    logic        lj_valid, lj_ovr, lj_serr, i2s_valid, i2s_ovr, i2s_serr;
    logic [15:0] lj_left, lj_right, i2s_left, i2s_right;
    logic [2:0]  lj_level, i2s_level;

    logic [31:0] q_lj[$];
    logic [31:0] q_i2s[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 bclk = ~bclk;

    mic_load_stereo #(.N(16), .DEPTH(4), .I2S_MODE(0)) u_lj (
        .bclk(bclk), .reset_n(reset_n), .adclrc(lj_lrc), .adcdat(lj_dat),
        .out_valid(lj_valid), .out_ready(lj_ready), .out_left(lj_left),
        .out_right(lj_right), .level(lj_level), .overrun(lj_ovr),
        .sync_err(lj_serr), .clear_flags(lj_clr)
    );

    mic_load_stereo #(.N(16), .DEPTH(4), .I2S_MODE(1)) u_i2s (
        .bclk(bclk), .reset_n(reset_n), .adclrc(i2s_lrc), .adcdat(i2s_dat),
        .out_valid(i2s_valid), .out_ready(i2s_ready), .out_left(i2s_left),
        .out_right(i2s_right), .level(i2s_level), .overrun(i2s_ovr),
        .sync_err(i2s_serr), .clear_flags(i2s_clr)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One channel slot; dly=1 puts the MSB one BCLK after the channel edge.
    task automatic drive_slot(input bit sel, input bit lrc, input logic [15:0] w,
                              input int len, input int dly, input bit chk_lat,
                              input bit pop_at_push);
        int   idx;
        logic bitv;
        for (int k = 0; k < len; k++) begin
            @(negedge bclk);
            idx  = k - dly;
            bitv = (idx >= 0 && idx < 16) ? w[15-idx] : 1'b0;
            if (sel) begin
                i2s_lrc = lrc;
                i2s_dat = bitv;
            end else begin
                lj_lrc = lrc;
                lj_dat = bitv;
            end
            if (chk_lat && k == 16 + dly) check_eq("lat_lsb_edge", sel ? i2s_valid : lj_valid, 0);
            if (chk_lat && k == 17 + dly) check_eq("lat_push_edge", sel ? i2s_valid : lj_valid, 1);
            if (pop_at_push && !sel && k == 16 + dly) lj_ready = 1'b1;
            if (pop_at_push && !sel && k == 17 + dly) lj_ready = 1'b0;
        end
    endtask

    task automatic send_pair(input bit sel, input logic [15:0] l, input logic [15:0] r,
                             input int dly, input bit expect_frame,
                             input logic [15:0] el, input logic [15:0] er,
                             input bit chk_lat, input bit pop_at_push);
        if (expect_frame) begin
            if (sel) q_i2s.push_back({el, er});
            else     q_lj.push_back({el, er});
        end
        drive_slot(sel, ~sel, l, 32, dly, 1'b0, 1'b0);
        drive_slot(sel, sel, r, 32, dly, chk_lat, pop_at_push);
    endtask

    task automatic drain(input bit sel, input int cycles);
        @(negedge bclk);
        if (sel) i2s_ready = 1'b1; else lj_ready = 1'b1;
        repeat (cycles) @(negedge bclk);
        if (sel) i2s_ready = 1'b0; else lj_ready = 1'b0;
        #1;
        check_eq(sel ? "i2s_drain_level" : "lj_drain_level", sel ? i2s_level : lj_level, 0);
    endtask

    task automatic pulse_clear(input bit sel);
        @(negedge bclk);
        if (sel) i2s_clr = 1'b1; else lj_clr = 1'b1;
        @(negedge bclk);
        if (sel) i2s_clr = 1'b0; else lj_clr = 1'b0;
        #1;
    endtask

    initial begin : mon_lj
        logic [31:0] e;
        forever begin
            @(negedge bclk);
            #1;
            if (reset_n && lj_valid && lj_ready) begin
                $display("lj  pop: L=%h R=%h level=%0d", lj_left, lj_right, lj_level);
                if (q_lj.size() == 0) begin
                    check_eq("lj_unexpected_frame", q_lj.size(), 1);
                end else begin
                    e = q_lj.pop_front();
                    check_eq("lj_frame", {lj_left, lj_right}, e);
                end
            end
        end
    end

    initial begin : mon_i2s
        logic [31:0] e;
        forever begin
            @(negedge bclk);
            #1;
            if (reset_n && i2s_valid && i2s_ready) begin
                $display("i2s pop: L=%h R=%h level=%0d", i2s_left, i2s_right, i2s_level);
                if (q_i2s.size() == 0) begin
                    check_eq("i2s_unexpected_frame", q_i2s.size(), 1);
                end else begin
                    e = q_i2s.pop_front();
                    check_eq("i2s_frame", {i2s_left, i2s_right}, e);
                end
            end
        end
    end

    initial begin : stim
        logic [15:0] fl, fr;
        reset_n = 1'b0;
        lj_lrc = 1'b0;  lj_dat = 1'b0;  lj_ready = 1'b0;  lj_clr = 1'b0;
        i2s_lrc = 1'b1; i2s_dat = 1'b0; i2s_ready = 1'b0; i2s_clr = 1'b0;
        repeat (3) @(negedge bclk);
        #1;
        check_eq("rst_valid", lj_valid, 0);
        check_eq("rst_level", lj_level, 0);
        check_eq("rst_flags", {lj_ovr, lj_serr, i2s_ovr, i2s_serr}, 0);
        check_eq("rst_data", {lj_left, lj_right}, 0);
        @(negedge bclk);
        reset_n = 1'b1;

        // Basic LJ frame with latency check
        send_pair(0, 16'hA5C3, 16'h1234, 0, 1, 16'hA5C3, 16'h1234, 1, 0);
        check_eq("lj_level_one", lj_level, 1);
        drain(0, 4);

        // Basic I2S frame
        send_pair(1, 16'hA5C3, 16'h1234, 1, 1, 16'hA5C3, 16'h1234, 1, 0);
        check_eq("i2s_level_one", i2s_level, 1);
        drain(1, 4);

        // LJ timing into the I2S build shifts each word by one bit
        send_pair(1, 16'hA5C3, 16'h1234, 0, 1, 16'h4B86, 16'h2468, 0, 0);
        drain(1, 4);

        // Five frames into a four-deep FIFO with no consumer
        for (int i = 0; i < 5; i++) begin
            fl = 16'hC0A0 + 16'(i);
            fr = 16'h0F50 + 16'(i * 3);
            send_pair(0, fl, fr, 0, i < 4, fl, fr, 0, 0);
        end
        check_eq("ovr_level", lj_level, 4);
        check_eq("ovr_flag", lj_ovr, 1);
        pulse_clear(0);
        check_eq("ovr_cleared", lj_ovr, 0);

        // Pop and push on the same edge while full
        send_pair(0, 16'hBEEF, 16'hCAFE, 0, 1, 16'hBEEF, 16'hCAFE, 0, 1);
        check_eq("full_pp_level", lj_level, 4);
        check_eq("full_pp_ovr", lj_ovr, 0);
        drain(0, 8);

        // Left channel cut after 10 bits
        drive_slot(0, 1'b1, 16'hFFFF, 10, 0, 1'b0, 1'b0);
        drive_slot(0, 1'b0, 16'h5555, 32, 0, 1'b0, 1'b0);
        check_eq("cut_sync_err", lj_serr, 1);
        check_eq("cut_no_frame", lj_level, 0);
        pulse_clear(0);
        check_eq("cut_cleared", lj_serr, 0);
        send_pair(0, 16'h3C3C, 16'hC3A5, 0, 1, 16'h3C3C, 16'hC3A5, 0, 0);
        check_eq("cut_recover_level", lj_level, 1);
        drain(0, 4);

        // Reset mid-SHIFT with a frame waiting in the FIFO
        send_pair(0, 16'h1357, 16'h2468, 0, 1, 16'h1357, 16'h2468, 0, 0);
        drive_slot(0, 1'b1, 16'h9ABC, 8, 0, 1'b0, 1'b0);
        @(negedge bclk);
        reset_n = 1'b0;
        lj_lrc  = 1'b0;
        #1;
        check_eq("midrst_valid", lj_valid, 0);
        check_eq("midrst_level", lj_level, 0);
        check_eq("midrst_data", {lj_left, lj_right}, 0);
        check_eq("midrst_flags", {lj_ovr, lj_serr}, 0);
        q_lj.delete();
        repeat (2) @(negedge bclk);
        reset_n = 1'b1;
        drive_slot(0, 1'b0, 16'h7777, 20, 0, 1'b0, 1'b0);
        check_eq("midright_no_frame", lj_level, 0);
        send_pair(0, 16'h0F0F, 16'hF00D, 0, 1, 16'h0F0F, 16'hF00D, 0, 0);
        check_eq("postrst_level", lj_level, 1);
        drain(0, 4);

        check_eq("i2s_no_sync_err", i2s_serr, 0);
        check_eq("lj_queue_empty", q_lj.size(), 0);
        check_eq("i2s_queue_empty", q_i2s.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mic_load_stereo.md
Name: mic_load_stereo

Overview:
- Parametrised stereo successor to the mono ADC-serial receiver.
- Deserialises the CODEC ADCDAT stream into left/right N-bit samples, in either left-justified (LJ) or I2S framing.
- Pairs each left sample with its right sample into one frame and buffers frames in a small FIFO.
- Adds ready/valid backpressure toward the DSP side, plus sticky overrun and sync-error flags.

Parameters:
- N, 16, sample width in bits (8..32); MSB first on the wire.
- DEPTH, 4, FIFO depth in stereo frames; power of two, at least 2.
- I2S_MODE, 0, 0 = LJ framing (MSB on the first BCLK after the ADCLRC edge), 1 = I2S framing (MSB one BCLK later).

Ports:
- bclk  in  1  bit clock; the single clock for the block; all sampling on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- adclrc  in  1  CODEC channel clock.
- adcdat  in  1  CODEC serial data.
- out_valid  out  1  FIFO head holds a frame.
- out_ready  in  1  consumer accepts the head frame this cycle.
- out_left  out  N  left sample of the head frame.
- out_right  out  N  right sample of the head frame.
- level  out  $clog2(DEPTH)+1  frames currently stored.
- overrun  out  1  sticky: a completed frame was dropped because the FIFO was full.
- sync_err  out  1  sticky: a channel ended before N bits were captured.
- clear_flags  in  1  synchronous clear of overrun and sync_err.

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE. All outputs are 0. FIFO is empty, pointers are 0, flags are clear. A reset mid-frame discards all partial data.
- Edge detect: adclrc_q is a registered copy of adclrc. An edge exists when adclrc != adclrc_q.
- Left channel start: LJ uses the rising edge; I2S uses the falling edge.
- Right channel start: LJ uses the falling edge; I2S uses the rising edge.
- States: IDLE, DELAY, SHIFT, WAIT.
- IDLE: ignores right-start edges, so a frame is always left first. A left-start edge moves to SHIFT in LJ mode, or to DELAY in I2S mode.
- LJ MSB timing: the adcdat sampled on the same edge that detects the left-start edge is the MSB. bit_cnt becomes 1 and the FSM enters SHIFT.
- DELAY: lasts one cycle with no sample taken. The next edge samples the MSB and the FSM enters SHIFT.
- SHIFT: each edge stores adcdat at bit (N-1)-bit_cnt and increments bit_cnt.
- SHIFT completion: on the edge that stores bit 0, the left sample is latched into hold_left, or the right sample completes the frame. The FSM then enters WAIT.
- WAIT: trailing slot bits are ignored until the next channel edge. A right-start edge begins right capture, exactly like the left case. A left-start edge restarts left capture, and any captured left with no right is discarded.
- Short channel: a channel edge arriving in SHIFT or DELAY before N bits sets sync_err. The partial word is discarded and capture restarts for the new channel, as in WAIT.
- A right-start edge while no left sample is held is ignored and does not set sync_err.
- Frame push: occurs on the edge after the right LSB is stored (one-cycle latency). The pair {hold_left, right} is written at wr_ptr.
- out_valid rises after the push edge when the FIFO was empty.
- FIFO is first-word fall-through: out_left/out_right are driven from mem[rd_ptr] and are stable while out_valid=1 and out_ready=0.
- Pop happens when out_valid && out_ready.
- Push when full: the frame is dropped, overrun is set, and FIFO contents are unchanged.
- Push and pop in the same cycle when full: the pop frees space, the push is accepted, and level is unchanged.
- Push and pop in the same cycle when empty: no pop occurs (out_valid is 0); the push is accepted and level becomes 1.
- Pointers are log2(DEPTH) bits and wrap naturally. level = wr_cnt - rd_cnt, tracked with an extra bit.
- clear_flags clears both flags. A clear coinciding with a new set event: the set wins.

Test Plan:
- LJ, N=16: send left 0xA5C3 then right 0x1234, with 32-bit slots -> one frame out_left=0xA5C3, out_right=0x1234; out_valid rises 1 edge after the right LSB edge; level=1.
- I2S_MODE=1: same words, MSB one BCLK after each edge -> identical frame. Driving LJ timing into the I2S build must produce 0x4B86 for left (shifted by one bit).
- out_ready=0 and 5 frames sent with DEPTH=4 -> level=4, overrun=1, the first 4 frames are retained in order. clear_flags -> overrun=0.
- Full FIFO: a pop and a push on the same edge -> level stays 4, no overrun, the new frame appears last.
- Left channel cut after 10 bits by a right edge -> sync_err=1, no frame pushed. The next complete pair is pushed correctly.
- Stream starting mid-right channel, and reset_n pulsed mid-SHIFT -> no frame until a full left+right pair after release; all outputs 0 during reset.
